// File: rtl/div_sequencer.sv
// Iterative RV32IM divide unit (DIV/DIVU/REM/REMU) for the execute stage.
// 32-step restoring division on operand magnitudes, with sign fix-up and special-case bypass.
module div_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            START,
    input  logic [1:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            STALL,
    output logic            VALID,
    output logic [XLEN-1:0] RESULT
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e           state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quot;
    logic [XLEN-1:0]  divisor;
    logic             is_rem;
    logic             quot_neg;
    logic             rem_neg;

    logic            is_signed;
    logic            overflow;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] rem_shift;
    logic [XLEN+1:0] trial;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;

    assign is_signed = ~FUNCT3[0];
    assign overflow  = is_signed && (OPERAND_A == MinNeg) && (OPERAND_B == '1);
    assign a_mag     = (is_signed && OPERAND_A[XLEN-1]) ? -OPERAND_A : OPERAND_A;
    assign b_mag     = (is_signed && OPERAND_B[XLEN-1]) ? -OPERAND_B : OPERAND_B;

    // Shifted partial remainder can need XLEN+1 bits; the extra top bit gives the borrow.
    assign rem_shift = {rem[XLEN-2:0], quot[XLEN-1]};
    assign trial     = {1'b0, rem, quot[XLEN-1]} - {2'b00, divisor};

    assign quot_fix = quot_neg ? -quot : quot;
    assign rem_fix  = rem_neg ? -rem : rem;

    assign BUSY  = (state != StIdle);
    assign VALID = (state == StDone);
    // Gated by reset so a pipeline still holding START sees no stall during reset.
    assign STALL = RESETN & (((state == StIdle) & START & ~FLUSH) |
                             (state == StCalc) | (state == StFix));

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= StIdle;
            count    <= '0;
            rem      <= '0;
            quot     <= '0;
            divisor  <= '0;
            is_rem   <= 1'b0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            RESULT   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (START && !FLUSH) begin
                        if (OPERAND_B == '0) begin
                            RESULT <= FUNCT3[1] ? OPERAND_A : '1;
                            state  <= StDone;
                        end else if (overflow) begin
                            RESULT <= FUNCT3[1] ? '0 : MinNeg;
                            state  <= StDone;
                        end else begin
                            rem      <= '0;
                            quot     <= a_mag;
                            divisor  <= b_mag;
                            is_rem   <= FUNCT3[1];
                            quot_neg <= is_signed & (OPERAND_A[XLEN-1] ^ OPERAND_B[XLEN-1]);
                            rem_neg  <= is_signed & OPERAND_A[XLEN-1];
                            count    <= '0;
                            state    <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (FLUSH) begin
                        count <= '0;
                        state <= StIdle;
                    end else begin
                        if (!trial[XLEN+1]) begin
                            rem  <= trial[XLEN-1:0];
                            quot <= {quot[XLEN-2:0], 1'b1};
                        end else begin
                            rem  <= rem_shift;
                            quot <= {quot[XLEN-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                        if (count == CNT_W'(XLEN - 1)) begin
                            state <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (FLUSH) begin
                        count <= '0;
                        state <= StIdle;
                    end else begin
                        RESULT <= is_rem ? rem_fix : quot_fix;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
